// File: rtl/ll_auto_sync_nch_if.sv
// Control, userbit and status signals of the multi-channel auto-sync block.
// The master side drives the requests; the slave side is the sync block itself.
interface ll_auto_sync_nch_if #(
   parameter int NUM_CH       = 8,
   parameter int MARKER_WIDTH = 2,
   parameter int DELAY_WIDTH  = 16,
   parameter int INTV_WIDTH   = 8
);
   logic                    tx_online;
   logic [NUM_CH-1:0]       rx_online;
   logic                    rx_online_holdoff;
   logic [DELAY_WIDTH-1:0]  delay_x_value;
   logic [DELAY_WIDTH-1:0]  delay_y_value;
   logic [DELAY_WIDTH-1:0]  delay_z_value;
   logic [INTV_WIDTH-1:0]   pulse_interval;
   logic [MARKER_WIDTH-1:0] tx_mrk_userbit;
   logic                    tx_stb_userbit;
   logic                    err_clr;

   logic                    tx_online_delay;
   logic [MARKER_WIDTH-1:0] tx_auto_mrk_userbit;
   logic                    tx_auto_stb_userbit;
   logic                    rx_online_delay;
   logic [NUM_CH-1:0]       rx_drop_err;
   logic [31:0]             debug_status;

   modport master (
      output tx_online, rx_online, rx_online_holdoff,
      output delay_x_value, delay_y_value, delay_z_value, pulse_interval,
      output tx_mrk_userbit, tx_stb_userbit, err_clr,
      input  tx_online_delay, tx_auto_mrk_userbit, tx_auto_stb_userbit,
      input  rx_online_delay, rx_drop_err, debug_status
   );

   modport slave (
      input  tx_online, rx_online, rx_online_holdoff,
      input  delay_x_value, delay_y_value, delay_z_value, pulse_interval,
      input  tx_mrk_userbit, tx_stb_userbit, err_clr,
      output tx_online_delay, tx_auto_mrk_userbit, tx_auto_stb_userbit,
      output rx_online_delay, rx_drop_err, debug_status
   );
endinterface

// File: rtl/ll_auto_sync_nch.sv
// Multi-channel auto-sync: delayed TX/RX online sequencing, marker/strobe
// userbit generation and sticky logging of channel drops while RX is active.
module ll_auto_sync_nch #(
   parameter int NUM_CH            = 8,
   parameter int MARKER_WIDTH      = 2,
   parameter int DELAY_WIDTH       = 16,
   parameter bit PERSISTENT_MARKER = 1'b1,
   parameter bit PERSISTENT_STROBE = 1'b1,
   parameter int INTV_WIDTH        = 8
) (
   input  logic               clk_wr,
   input  logic               rst_wr_n,
   ll_auto_sync_nch_if.slave  bus
);

   typedef enum logic [1:0] {
      TX_IDLE   = 2'd0,
      TX_WAIT_Z = 2'd1,
      TX_WAIT_Y = 2'd2,
      TX_ACTIVE = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_WAIT_X = 2'd1,
      RX_ACTIVE = 2'd3
   } rx_state_t;

   tx_state_t               r_tx_state;
   rx_state_t               r_rx_state;
   logic [DELAY_WIDTH-1:0]  r_tx_cnt;
   logic [DELAY_WIDTH-1:0]  r_rx_cnt;
   logic [INTV_WIDTH-1:0]   r_intv_cnt;
   logic                    r_tx_delay;
   logic                    r_rx_delay;
   logic [MARKER_WIDTH-1:0] r_mrk;
   logic                    r_stb;
   logic [NUM_CH-1:0]       r_drop_err;
   logic [7:0]              r_drop_cnt;

   logic                    w_rx_all;
   logic                    w_drop;
   logic                    w_pulse_slot;
   logic [DELAY_WIDTH-1:0]  w_tx_cnt_inc;
   logic [DELAY_WIDTH-1:0]  w_rx_cnt_inc;
   logic [7:0]              w_drop_cnt_inc;

   assign w_rx_all       = &bus.rx_online;
   assign w_drop         = (r_rx_state == RX_ACTIVE) && !w_rx_all;
   assign w_pulse_slot   = (r_intv_cnt == '0);
   assign w_tx_cnt_inc   = (r_tx_cnt == '1) ? r_tx_cnt : r_tx_cnt + DELAY_WIDTH'(1);
   assign w_rx_cnt_inc   = (r_rx_cnt == '1) ? r_rx_cnt : r_rx_cnt + DELAY_WIDTH'(1);
   assign w_drop_cnt_inc = (r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1;

   // TX sequencer; dropping tx_online returns to idle from any state.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_intv_cnt <= '0;
         r_tx_delay <= 1'b0;
         r_mrk      <= '0;
         r_stb      <= 1'b0;
      end else if (!bus.tx_online) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_intv_cnt <= '0;
         r_tx_delay <= 1'b0;
         r_mrk      <= '0;
         r_stb      <= 1'b0;
      end else begin
         // NOTE: userbits default to 0 each cycle so only TX_ACTIVE can drive them.
         r_mrk <= '0;
         r_stb <= 1'b0;
         case (r_tx_state)
            TX_IDLE: begin
               r_tx_state <= TX_WAIT_Z;
               r_tx_cnt   <= '0;
            end
            TX_WAIT_Z: begin
               if (r_tx_cnt >= bus.delay_z_value) begin
                  r_tx_state <= TX_WAIT_Y;
                  r_tx_cnt   <= '0;
                  r_tx_delay <= 1'b1;
               end else begin
                  r_tx_cnt <= w_tx_cnt_inc;
               end
            end
            TX_WAIT_Y: begin
               if (r_tx_cnt >= bus.delay_y_value) begin
                  r_tx_state <= TX_ACTIVE;
                  r_tx_cnt   <= '0;
                  r_intv_cnt <= '0;
               end else begin
                  r_tx_cnt <= w_tx_cnt_inc;
               end
            end
            TX_ACTIVE: begin
               r_intv_cnt <= (r_intv_cnt >= bus.pulse_interval) ? '0 : r_intv_cnt + INTV_WIDTH'(1);
               if (PERSISTENT_MARKER || w_pulse_slot) r_mrk <= bus.tx_mrk_userbit;
               if (PERSISTENT_STROBE || w_pulse_slot) r_stb <= bus.tx_stb_userbit;
            end
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

   // RX sequencer; holdoff only matters before RX_ACTIVE is reached.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_delay <= 1'b0;
      end else begin
         case (r_rx_state)
            RX_IDLE: begin
               r_rx_cnt <= '0;
               if (w_rx_all && !bus.rx_online_holdoff) r_rx_state <= RX_WAIT_X;
            end
            RX_WAIT_X: begin
               if (!w_rx_all || bus.rx_online_holdoff) begin
                  r_rx_state <= RX_IDLE;
                  r_rx_cnt   <= '0;
               end else if (r_rx_cnt >= bus.delay_x_value) begin
                  r_rx_state <= RX_ACTIVE;
                  r_rx_cnt   <= '0;
                  r_rx_delay <= 1'b1;
               end else begin
                  r_rx_cnt <= w_rx_cnt_inc;
               end
            end
            RX_ACTIVE: begin
               if (!w_rx_all) begin
                  r_rx_state <= RX_IDLE;
                  r_rx_delay <= 1'b0;
               end
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

   // Sticky drop log; a drop in the same cycle as err_clr survives the clear.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         r_drop_err <= '0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_drop_err <= (bus.err_clr ? '0 : r_drop_err) | ~bus.rx_online;
         r_drop_cnt <= bus.err_clr ? 8'd1 : w_drop_cnt_inc;
      end else if (bus.err_clr) begin
         r_drop_err <= '0;
         r_drop_cnt <= '0;
      end
   end

   assign bus.tx_online_delay     = r_tx_delay;
   assign bus.tx_auto_mrk_userbit = r_mrk;
   assign bus.tx_auto_stb_userbit = r_stb;
   assign bus.rx_online_delay     = r_rx_delay;
   assign bus.rx_drop_err         = r_drop_err;
   assign bus.debug_status        = {16'd0, r_drop_cnt, 2'b00, r_rx_delay, r_tx_delay,
                                     r_rx_state, r_tx_state};

endmodule
